// File: rtl/moving_sum_filter.sv
// Power-of-two moving-window sum/average over an ADC sample stream, with an optional
// threshold/peak detector built only when MOVING_SUM_FILTER_PEAK_EN is defined.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_FILL  | window (re)filling: accumulate only, out_valid low
// ST_RUN   | window full: add newest sample, subtract the one leaving
// PK_IDLE  | waiting for a valid average above threshold
// PK_ABOVE | inside a pulse: tracking its maximum and width
module moving_sum_filter #(
    parameter int IN_W       = 12,
    parameter int LOG2_DEPTH = 5,
    localparam int SUM_W     = IN_W + LOG2_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IN_W-1:0]   input_data,
    input  logic [2:0]        win_log2,
    input  logic [IN_W-1:0]   threshold,
    output logic [SUM_W-1:0]  output_sum,
    output logic [IN_W-1:0]   output_avg,
    output logic              out_valid,
    output logic              peak_valid,
    output logic [IN_W-1:0]   peak_value,
    output logic [15:0]       peak_width
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int CNT_W = LOG2_DEPTH + 1;
    localparam int PTR_W = LOG2_DEPTH;

    localparam logic [0:0] ST_FILL  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] PK_IDLE  = 1'b0;
    localparam logic [0:0] PK_ABOVE = 1'b1;

    logic [IN_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rd_addr;
    logic [IN_W-1:0]  old_sample;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] win_len;
    logic [2:0]       win_eff;
    logic [2:0]       win_reg_q, win_reg_d;
    logic [0:0]       state_q, state_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [IN_W-1:0]  avg_q, avg_d;
    logic             valid_q, valid_d;
    logic             fill_entry;

    always_comb begin
        win_eff    = (int'(win_log2) > LOG2_DEPTH) ? 3'(LOG2_DEPTH) : win_log2;
        win_len    = CNT_W'(1) << win_eff;
        fill_entry = (win_eff != win_reg_q);
        // With W = DEPTH this aliases wptr; the read sees the pre-write contents.
        rd_addr    = wptr_q - win_len[PTR_W-1:0];
        old_sample = mem_q[rd_addr];
        wptr_d     = wptr_q + PTR_W'(1);

        state_d   = state_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        win_reg_d = win_reg_q;

        if (fill_entry) begin
            win_reg_d = win_eff;
            sum_d     = SUM_W'(input_data);
            cnt_d     = CNT_W'(1);
            valid_d   = 1'b0;
            state_d   = ST_FILL;
            if (cnt_d == win_len) begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
        end else if (state_q == ST_FILL) begin
            sum_d = sum_q + SUM_W'(input_data);
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == win_len) begin
                state_d = ST_RUN;
                valid_d = 1'b1;
            end
        end else begin
            sum_d   = sum_q + SUM_W'(input_data) - SUM_W'(old_sample);
            valid_d = 1'b1;
        end

        avg_d = IN_W'(sum_d >> win_eff);
    end

    always_ff @(posedge clk) begin
        mem_q[wptr_q] <= input_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q    <= '0;
            cnt_q     <= '0;
            win_reg_q <= '0;
            state_q   <= ST_FILL;
            sum_q     <= '0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            cnt_q     <= cnt_d;
            win_reg_q <= win_reg_d;
            state_q   <= state_d;
            sum_q     <= sum_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
        end
    end

    assign output_sum = sum_q;
    assign output_avg = avg_q;
    assign out_valid  = valid_q;

`ifdef MOVING_SUM_FILTER_PEAK_EN
    logic [0:0]      pk_state_q, pk_state_d;
    logic [IN_W-1:0] pk_q, pk_d;
    logic [15:0]     wd_q, wd_d;
    logic            pv_q, pv_d;
    logic [IN_W-1:0] pval_q, pval_d;
    logic [15:0]     pwid_q, pwid_d;

    always_comb begin
        pk_state_d = pk_state_q;
        pk_d       = pk_q;
        wd_d       = wd_q;
        pv_d       = 1'b0;
        pval_d     = pval_q;
        pwid_d     = pwid_q;

        // A window change restarts the fill, so any pulse in progress is dropped.
        if (fill_entry) begin
            pk_state_d = PK_IDLE;
        end else if (pk_state_q == PK_IDLE) begin
            if (valid_q && (avg_q > threshold)) begin
                pk_state_d = PK_ABOVE;
                pk_d       = avg_q;
                wd_d       = 16'd1;
            end
        end else begin
            if (avg_q > threshold) begin
                if (wd_q != 16'hFFFF) wd_d = wd_q + 16'd1;
                if (avg_q > pk_q)     pk_d = avg_q;
            end else begin
                pv_d       = 1'b1;
                pval_d     = pk_q;
                pwid_d     = wd_q;
                pk_state_d = PK_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pk_state_q <= PK_IDLE;
            pk_q       <= '0;
            wd_q       <= '0;
            pv_q       <= 1'b0;
            pval_q     <= '0;
            pwid_q     <= '0;
        end else begin
            pk_state_q <= pk_state_d;
            pk_q       <= pk_d;
            wd_q       <= wd_d;
            pv_q       <= pv_d;
            pval_q     <= pval_d;
            pwid_q     <= pwid_d;
        end
    end

    assign peak_valid = pv_q;
    assign peak_value = pval_q;
    assign peak_width = pwid_q;
`else
    logic unused_threshold;
    assign unused_threshold = ^threshold;

    assign peak_valid = 1'b0;
    assign peak_value = '0;
    assign peak_width = '0;
`endif

endmodule

// File: tb/tb_moving_sum_filter.sv
// Directed bench for moving_sum_filter; peak expectations follow MOVING_SUM_FILTER_PEAK_EN.
module tb_moving_sum_filter;

`ifdef MOVING_SUM_FILTER_PEAK_EN
    localparam int PK = 1;
`else
    localparam int PK = 0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] input_data;
    logic [2:0]  win_log2;
    logic [11:0] threshold;
    logic [16:0] output_sum;
    logic [11:0] output_avg;
    logic        out_valid;
    logic        peak_valid;
    logic [11:0] peak_value;
    logic [15:0] peak_width;

    int n_assert = 0;
    int n_fail   = 0;

    moving_sum_filter dut (
        .clk        (clk),
        .reset      (reset),
        .input_data (input_data),
        .win_log2   (win_log2),
        .threshold  (threshold),
        .output_sum (output_sum),
        .output_avg (output_avg),
        .out_valid  (out_valid),
        .peak_valid (peak_valid),
        .peak_value (peak_value),
        .peak_width (peak_width)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int d);
        input_data = d[11:0];
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sum"},   int'(output_sum), 0);
        check({tag, "_avg"},   int'(output_avg), 0);
        check({tag, "_valid"}, int'(out_valid),  0);
        check({tag, "_pv"},    int'(peak_valid), 0);
        check({tag, "_pval"},  int'(peak_value), 0);
        check({tag, "_pwid"},  int'(peak_width), 0);
    endtask

    initial begin
        reset      = 1'b1;
        input_data = '0;
        win_log2   = 3'd2;
        threshold  = 12'd4095;
        #2;
        tick(0);
        tick(0);
        check_all_zero("reset");
        reset = 1'b0;

        // Constant 100, window 4: fill sums then 400 held
        for (int i = 1; i <= 6; i++) begin
            tick(100);
            check("s1_valid", int'(out_valid), (i >= 4) ? 1 : 0);
            check("s1_sum", int'(output_sum), (i >= 4) ? 400 : 100 * i);
            if (i >= 4) check("s1_avg", int'(output_avg), 100);
        end

        // Step from 0 to 1000
        for (int i = 1; i <= 4; i++) tick(0);
        check("s2_zero_sum", int'(output_sum), 0);
        for (int i = 1; i <= 5; i++) begin
            tick(1000);
            check("s2_sum", int'(output_sum), (i >= 4) ? 4000 : 1000 * i);
            check("s2_avg", int'(output_avg), (i >= 4) ? 1000 : 250 * i);
            check("s2_valid", int'(out_valid), 1);
        end

        // Window change 4 -> 8
        for (int i = 1; i <= 4; i++) tick(100);
        check("s3_pre_sum", int'(output_sum), 400);
        win_log2 = 3'd3;
        for (int i = 1; i <= 8; i++) begin
            tick(100);
            check("s3_valid", int'(out_valid), (i == 8) ? 1 : 0);
            if (i == 1) check("s3_first_sum", int'(output_sum), 100);
        end
        check("s3_sum", int'(output_sum), 800);
        check("s3_avg", int'(output_avg), 100);

        // Clamp: win_log2 = 7 -> 32-sample window
        win_log2 = 3'd7;
        for (int i = 1; i <= 32; i++) begin
            tick(10);
            if (i == 1)  check("s5_first_sum", int'(output_sum), 10);
            if (i == 31) check("s5_valid_31", int'(out_valid), 0);
        end
        check("s5_valid", int'(out_valid), 1);
        check("s5_sum", int'(output_sum), 320);
        check("s5_avg", int'(output_avg), 10);
        tick(10);
        check("s5_hold_sum", int'(output_sum), 320);

        // Peak: window 1, threshold 50
        win_log2  = 3'd0;
        threshold = 12'd50;
        tick(0);
        check("s4_pv0", int'(peak_valid), 0);
        tick(60);
        check("s4_pv60", int'(peak_valid), 0);
        tick(90);
        check("s4_avg90", int'(output_avg), 90);
        check("s4_pv90", int'(peak_valid), 0);
        tick(70);
        check("s4_pv70", int'(peak_valid), 0);
        tick(40);
        check("s4_avg40", int'(output_avg), 40);
        check("s4_pv40", int'(peak_valid), 0);
        tick(0);
        check("s4_pv", int'(peak_valid), PK);
        check("s4_pval", int'(peak_value), 90 * PK);
        check("s4_pwid", int'(peak_width), 3 * PK);
        tick(0);
        check("s4_pv_end", int'(peak_valid), 0);
        check("s4_pval_hold", int'(peak_value), 90 * PK);
        check("s4_pwid_hold", int'(peak_width), 3 * PK);

        // Reset while inside a pulse
        tick(200);
        tick(200);
        check("s6_avg", int'(output_avg), 200);
        reset = 1'b1;
        tick(200);
        check_all_zero("s6_reset");
        reset     = 1'b0;
        threshold = 12'd4095;
        win_log2  = 3'd2;
        for (int i = 1; i <= 5; i++) begin
            tick(100);
            check("s6_valid", int'(out_valid), (i >= 4) ? 1 : 0);
            check("s6_sum", int'(output_sum), (i >= 4) ? 400 : 100 * i);
            check("s6_pv", int'(peak_valid), 0);
        end
        check("s6_pval", int'(peak_value), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/moving_sum_filter.md
# moving_sum_filter

Parametrised moving-window shaper, the generalised successor to the fixed per-variant filters hung off `exp_sig_gen` in the filter top level. Each clock it takes one ADC sample and produces a running window sum and its average, with the window length selectable at run time as a power of two. An optional threshold/peak detector reports pulse amplitude and width. It is instantiated in the filter top level with `input_data` driven by `output_data_exp_sig_gen`.

## Interface
- `IN_W`, default 12 (= SIZE_ADC_DATA): unsigned sample width.
- `LOG2_DEPTH`, default 5: delay-line depth is DEPTH = 2**LOG2_DEPTH, the maximum window.
- `SUM_W`, derived = IN_W + LOG2_DEPTH: accumulator width; must not be overridden.
- `clk`, input, 1: single clock, all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `input_data`, input, IN_W: unsigned sample, one per clock.
- `win_log2`, input, 3: window W = 2**min(win_log2, LOG2_DEPTH).
- `threshold`, input, IN_W: peak detector threshold, compared against `output_avg`.
- `output_sum`, output, SUM_W: sum of the last W samples.
- `output_avg`, output, IN_W: `output_sum >> win_eff`.
- `out_valid`, output, 1: high when the window is full.
- `peak_valid`, output, 1: one-cycle pulse marking the end of an above-threshold pulse.
- `peak_value`, output, IN_W: maximum `output_avg` seen in the pulse; held until the next `peak_valid`.
- `peak_width`, output, 16: number of valid cycles above threshold, saturating at 0xFFFF; held like `peak_value`.

## Operation
- **Effective window.** `win_eff` = min(win_log2, LOG2_DEPTH), registered as `win_reg`.
- **Delay line.** DEPTH-entry circular buffer with write pointer `wptr`. Every cycle `input_data` is written at `wptr`, then `wptr` increments and wraps. The old sample is read from `(wptr - W) mod DEPTH` before the write. When W = DEPTH this is the same address, and the old data must be returned.
- **FILL state.** Entered on reset and whenever `win_eff != win_reg`.
  - On entry: `sum <= input_data`, `cnt <= 1`, `win_reg <= win_eff`, `out_valid <= 0`.
  - While filling: `sum <= sum + input_data`, `cnt` increments, and no subtraction is done, so buffer contents are don't-care.
  - When the incoming sample is the W-th one, move to RUN and set `out_valid <= 1` in the same edge.
- **RUN state.** `sum <= sum + input_data - old`. `out_valid` stays 1.
- **Window change.** A window change takes priority over every other event. The sample in the change cycle becomes sample 1 of the new fill.
- **Arithmetic.**
  - The accumulator is unsigned SUM_W bits and never overflows, since W*(2**IN_W - 1) fits.
  - `output_avg` is computed from the next-sum value, so it is registered in the same edge as `output_sum`. Truncate, no rounding.
- **Peak detector states.**
  - IDLE: when `out_valid` && `output_avg > threshold`, go to ABOVE with `pk <= output_avg` and `wd <= 1`.
  - ABOVE, each cycle `output_avg > threshold`: `wd` increments with saturation, and `pk <= max(pk, output_avg)`.
  - ABOVE, first cycle `output_avg <= threshold`: `peak_valid <= 1`, `peak_value <= pk`, `peak_width <= wd`, go to IDLE.
  - FILL entry while in ABOVE: abort to IDLE with no pulse.
- **Reset values.** All outputs 0, `wptr` = 0, `cnt` = 0, FILL and IDLE states. The buffer RAM is not reset.

## Timing
- The sample presented before edge n is reflected in `output_sum`, `output_avg` and `out_valid` after edge n (1-cycle latency).
- After reset is released, `out_valid` first rises at the edge that samples the W-th input.
- `peak_valid` is asserted the edge after the first registered `output_avg <= threshold` and lasts exactly 1 cycle.
- There is no back-pressure; a new sample is accepted every clock.

## Configuration
- `MOVING_SUM_FILTER_PEAK_EN`
  - Defined: the peak detector is built as specified.
  - Undefined: no detector logic is built; `peak_valid`, `peak_value` and `peak_width` are tied to 0, and `threshold` is ignored.
  - The sum/avg path behaves identically either way.

## Test plan
Defaults IN_W=12, LOG2_DEPTH=5; `MOVING_SUM_FILTER_PEAK_EN` defined for scenarios 4 and 6.
1. **Constant input.** Reset, `win_log2`=2, constant input 100 → `out_valid` rises on the 4th sampling edge with `output_sum`=400, `output_avg`=100, and stays there.
2. **Step.** `win_log2`=2, run at 0, then step to 1000 → `output_sum` 1000, 2000, 3000, 4000, then 4000 held; `output_avg` 250, 500, 750, 1000.
3. **Window change.** Constant 100 with `win_log2` 2, then changed to 3 → `out_valid` = 0 from the next edge, returns after 8 samples with `output_sum`=800.
4. **Peak.** `win_log2`=0, `threshold`=50, input 0, 60, 90, 70, 40, 0 → single `peak_valid` pulse the edge after avg=40 is output, with `peak_value`=90 and `peak_width`=3.
5. **Clamp.** `win_log2`=7, constant 10 → window clamps to 32; `out_valid` after 32 samples, `output_sum`=320, `output_avg`=10.
6. **Reset mid-pulse.** Assert `reset` while the detector is in ABOVE → all outputs 0 after that edge and no `peak_valid`; after release the FILL latency of scenario 1 is repeated.
